rx_shift_sequencer: RTL and testbench
=====================================

Name: rx_shift_sequencer

Overview:
- Bit-level sequencer for the USB receive datapath. Sits between the bit decoder and the field shift registers (sync/pid/crc5/data/crc16).
- Takes the per-field `*_rcving` levels from the receiver control unit and the per-bit `shift_strobe` from the decoder.
- Generates the per-field shift enables and the `*_bits_received` completion flags that the control unit waits on.
- Flags overrun and field-select conflicts.

Parameters:
- SYNC_BITS, 8, bits in sync field
- PID_BITS, 8, bits in PID field
- CRC5_BITS, 5, bits in token CRC
- DATA_BITS, 64, bits in data payload
- CRC16_BITS, 16, bits in data CRC
- CNT_W, 7, bit-counter width; must hold max field length (64)
- WDOG_CYCLES, 64, stall limit; used only with RX_SEQ_WATCHDOG_EN

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- shift_strobe  in  1  one-cycle pulse per decoded bit
- eop  in  1  end-of-packet detected
- sync_rcving, pid_rcving, crc5_rcving, data_rcving, crc16_rcving  in  1 each  field-select levels from control unit
- sync_shift_enable, pid_shift_enable, crc5_shift_enable, data_shift_enable, crc16_shift_enable  out  1 each  shift current bit into that field register
- sync_bits_received, pid_bits_received, crc5_bits_received, data_bits_received, crc16_bits_received  out  1 each  field complete
- field_overrun  out  1  sticky: strobe received after field already full
- field_conflict  out  1  more than one `*_rcving` high this cycle (combinational)
- stall_timeout  out  1  watchdog pulse (optional feature)

Behaviour:
- Registers:
  - `fld` ∈ {NONE, SYNC, PID, CRC5, DATA, CRC16}
  - `cnt[CNT_W-1:0]`
  - `ovr` (sticky overrun)
- Reset (`rst` high at posedge): `fld`=NONE, `cnt`=0, `ovr`=0. All outputs read 0 in the cycle after reset.
- Current field `cur`: decoded from the `*_rcving` one-hot.
  - No `*_rcving` high: `cur`=NONE.
  - More than one high: `cur`=NONE and `field_conflict`=1.
- Effective count `ecnt` = (`cur`==`fld`) ? `cnt` : 0. A field change restarts counting the same cycle.
- `N(cur)` = length parameter of `cur`.
- Shift enable: `X_shift_enable` = `shift_strobe` & (`cur`==X) & (`ecnt` < N(X)). Combinational; the bit is shifted in the same cycle as the strobe. Other enables are 0.
- Next state, when `cur`≠NONE:
  - `fld` <= `cur`.
  - `cnt` <= `ecnt` + 1 if a shift occurs, else `ecnt`.
- Next state, when `cur`=NONE: `fld` <= NONE, `cnt` <= 0.
- Completion: `X_bits_received` = (`fld`==X) & (`cur`==X) & (`cnt`==N(X)).
  - Asserts exactly one cycle after the Nth strobe.
  - Stays high while X remains selected (covers the control unit's compare cycle).
  - Drops combinationally when `*_rcving` changes.
- Overrun: strobe while `cur`≠NONE and `ecnt`==N(`cur`).
  - No shift; `cnt` holds.
  - `ovr` <= 1, held until `rst` or `eop`.
  - `field_overrun` = `ovr`.
- Strobes while `cur`=NONE (idle, EOP wait, compare states of other fields) are ignored: no shift, no overrun.
- `eop` high: `fld` <= NONE, `cnt` <= 0, `ovr` <= 0. `eop` takes priority over any simultaneous strobe; no shift occurs that cycle.
- `rst` takes priority over `eop` and strobe.
- Re-entry into the same field after leaving it (e.g. SYNC of the next packet) always starts from 0, because `fld` passed through NONE or another field.
- Direct X→Y transition with no gap, with a strobe in the transition cycle: the bit counts as bit 1 of Y.
- Counter never wraps; saturates at N.

Optional Feature:
- Macro: `RX_SEQ_WATCHDOG_EN`.
- Defined:
  - Adds a stall counter, cleared on every `shift_strobe`, on `cur`=NONE, and on field change.
  - Otherwise increments each cycle while `cur`≠NONE and `ecnt` < N(`cur`).
  - On reaching WDOG_CYCLES: `stall_timeout` pulses high for exactly one cycle and the counter clears. `cnt` and `fld` are unaffected.
- Undefined: no stall counter; `stall_timeout` tied 0.

Test Plan:
- Reset, then `sync_rcving`=1 with 8 strobes spaced 4 cycles apart → `sync_shift_enable` high on each strobe cycle; `sync_bits_received` rises 1 cycle after strobe 8; `field_overrun`=0.
- Token sequence: SYNC(8) → PID(8) → CRC5(5), each `*_rcving` dropped 1 cycle after its `bits_received` → exactly 8/8/5 enables per field; each `bits_received` asserted only in its own field.
- DATA field with 64 strobes then a 65th strobe before `data_rcving` drops → 64 enables, no 65th; `field_overrun`=1 and held until `eop` pulse, then 0.
- `pid_rcving` and `crc5_rcving` both high with a strobe → `field_conflict`=1, all enables 0, all `bits_received` 0.
- Strobe in the same cycle `sync_rcving` falls and `pid_rcving` rises → `pid_shift_enable`=1; after 7 more strobes `pid_bits_received`=1.
- `RX_SEQ_WATCHDOG_EN`, WDOG_CYCLES=64: `crc16_rcving` high, 3 strobes, then none for 64 cycles → single-cycle `stall_timeout` pulse; `cnt` still 3 (next strobe shifts, `crc16_bits_received` after 13 more). Macro undefined → `stall_timeout` stays 0.

Source files
------------

// File: rtl/rx_shift_sequencer.sv
// Bit-level sequencer between the USB bit decoder and the field shift registers.
// Optional stall watchdog enabled by defining RX_SEQ_WATCHDOG_EN.
module rx_shift_sequencer #(
    parameter int SYNC_BITS   = 8,
    parameter int PID_BITS    = 8,
    parameter int CRC5_BITS   = 5,
    parameter int DATA_BITS   = 64,
    parameter int CRC16_BITS  = 16,
    parameter int CNT_W       = 7,
    parameter int WDOG_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_strobe,
    input  logic eop,
    input  logic sync_rcving,
    input  logic pid_rcving,
    input  logic crc5_rcving,
    input  logic data_rcving,
    input  logic crc16_rcving,
    output logic sync_shift_enable,
    output logic pid_shift_enable,
    output logic crc5_shift_enable,
    output logic data_shift_enable,
    output logic crc16_shift_enable,
    output logic sync_bits_received,
    output logic pid_bits_received,
    output logic crc5_bits_received,
    output logic data_bits_received,
    output logic crc16_bits_received,
    output logic field_overrun,
    output logic field_conflict,
    output logic stall_timeout
);

    localparam int NF = 5;

    typedef enum logic [2:0] {
        F_NONE  = 3'd0,
        F_SYNC  = 3'd1,
        F_PID   = 3'd2,
        F_CRC5  = 3'd3,
        F_DATA  = 3'd4,
        F_CRC16 = 3'd5
    } fld_t;

    generate
        if (CNT_W < $clog2(DATA_BITS + 1)) begin : g_cnt_w_check
            $error("CNT_W too narrow for longest field");
        end
        if (WDOG_CYCLES < 2) begin : g_wdog_check
            $error("WDOG_CYCLES must be at least 2");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] len_of(input fld_t f);
        logic [CNT_W-1:0] n;
        n = '0;
        case (f)
            F_SYNC:  n = CNT_W'(SYNC_BITS);
            F_PID:   n = CNT_W'(PID_BITS);
            F_CRC5:  n = CNT_W'(CRC5_BITS);
            F_DATA:  n = CNT_W'(DATA_BITS);
            F_CRC16: n = CNT_W'(CRC16_BITS);
            default: n = '0;
        endcase
        return n;
    endfunction

    fld_t             fld_reg, fld_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovr_reg, ovr_next;

    logic [NF-1:0]    rcving;
    logic [NF-1:0]    shift_en;
    logic [NF-1:0]    bits_rcvd;
    logic [2:0]       hits;
    fld_t             cur;
    logic [CNT_W-1:0] n_cur;
    logic [CNT_W-1:0] ecnt;
    logic             room;
    logic             do_shift;
    logic             overrun;

    assign rcving = {crc16_rcving, data_rcving, crc5_rcving, pid_rcving, sync_rcving};

    // Only an exact one-hot selects a field; zero or several high means no field.
    always_comb begin
        hits = '0;
        cur  = F_NONE;
        for (int i = 0; i < NF; i++) begin
            if (rcving[i]) begin
                hits = hits + 3'd1;
                cur  = fld_t'(3'(i + 1));
            end
        end
        if (hits != 3'd1) begin
            cur = F_NONE;
        end
    end

    assign field_conflict = (hits > 3'd1);
    assign n_cur          = len_of(cur);
    assign ecnt           = (cur == fld_reg) ? cnt_reg : '0;
    assign room           = (cur != F_NONE) && (ecnt < n_cur);
    assign do_shift       = shift_strobe && !eop && room;
    assign overrun        = shift_strobe && !eop && (cur != F_NONE) && !room;

    generate
        for (genvar gi = 0; gi < NF; gi++) begin : g_field
            localparam fld_t FX = fld_t'(3'(gi + 1));
            assign shift_en[gi]  = do_shift && (cur == FX);
            assign bits_rcvd[gi] = (fld_reg == FX) && (cur == FX) && (cnt_reg == len_of(FX));
        end
    endgenerate

    assign {crc16_shift_enable, data_shift_enable, crc5_shift_enable,
            pid_shift_enable, sync_shift_enable} = shift_en;
    assign {crc16_bits_received, data_bits_received, crc5_bits_received,
            pid_bits_received, sync_bits_received} = bits_rcvd;
    assign field_overrun = ovr_reg;

    always_comb begin
        fld_next = fld_reg;
        cnt_next = cnt_reg;
        ovr_next = ovr_reg;
        if (eop) begin
            fld_next = F_NONE;
            cnt_next = '0;
            ovr_next = 1'b0;
        end else if (cur == F_NONE) begin
            fld_next = F_NONE;
            cnt_next = '0;
        end else begin
            fld_next = cur;
            cnt_next = do_shift ? (ecnt + CNT_W'(1)) : ecnt;
            if (overrun) begin
                ovr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fld_reg <= F_NONE;
            cnt_reg <= '0;
            ovr_reg <= 1'b0;
        end else begin
            fld_reg <= fld_next;
            cnt_reg <= cnt_next;
            ovr_reg <= ovr_next;
        end
    end

`ifdef RX_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_reg, wdog_next;
    logic              stall_reg, stall_next;

    // Counts only while a selected field is still waiting for bits.
    always_comb begin
        wdog_next  = '0;
        stall_next = 1'b0;
        if (!shift_strobe && !eop && room && (cur == fld_reg)) begin
            if (wdog_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
                stall_next = 1'b1;
            end else begin
                wdog_next = wdog_reg + WDOG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_reg  <= '0;
            stall_reg <= 1'b0;
        end else begin
            wdog_reg  <= wdog_next;
            stall_reg <= stall_next;
        end
    end

    assign stall_timeout = stall_reg;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rx_shift_sequencer.sv
// Directed bench for rx_shift_sequencer; watchdog expectations follow RX_SEQ_WATCHDOG_EN.
module tb_rx_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       shift_strobe;
    logic       eop;
    logic [4:0] rcv;
    logic [4:0] en;
    logic [4:0] rx;
    logic       field_overrun;
    logic       field_conflict;
    logic       stall_timeout;

    int         total  = 0;
    int         passed = 0;
    logic [4:0] e;
    int         n;
    int         stray;
    int         pulses;
    int         lens [3] = '{8, 8, 5};

    always #5 clk = ~clk;

    rx_shift_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .shift_strobe       (shift_strobe),
        .eop                (eop),
        .sync_rcving        (rcv[0]),
        .pid_rcving         (rcv[1]),
        .crc5_rcving        (rcv[2]),
        .data_rcving        (rcv[3]),
        .crc16_rcving       (rcv[4]),
        .sync_shift_enable  (en[0]),
        .pid_shift_enable   (en[1]),
        .crc5_shift_enable  (en[2]),
        .data_shift_enable  (en[3]),
        .crc16_shift_enable (en[4]),
        .sync_bits_received (rx[0]),
        .pid_bits_received  (rx[1]),
        .crc5_bits_received (rx[2]),
        .data_bits_received (rx[3]),
        .crc16_bits_received(rx[4]),
        .field_overrun      (field_overrun),
        .field_conflict     (field_conflict),
        .stall_timeout      (stall_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One-cycle strobe; enables are sampled mid-cycle, state is settled on return.
    task automatic strobe(output logic [4:0] ens);
        shift_strobe = 1'b1;
        #1;
        ens = en;
        tick();
        shift_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rcv = '0; shift_strobe = 1'b0; eop = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_en", en, 5'b0);
        chk("rst_rx", rx, 5'b0);
        chk("rst_ovr", field_overrun, 1'b0);
        chk("rst_conf", field_conflict, 1'b0);
        chk("rst_stall", stall_timeout, 1'b0);

        // SYNC with strobes spaced 4 cycles apart
        rcv = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            strobe(e);
            chk($sformatf("sync_en%0d", k), e, 5'b00001);
            chk($sformatf("sync_rx%0d", k), rx, (k == 8) ? 5'b00001 : 5'b0);
            tick(); tick(); tick();
        end
        chk("sync_rx_hold", rx, 5'b00001);
        chk("sync_ovr", field_overrun, 1'b0);
        rcv = '0;
        #1;
        chk("sync_rx_drop", rx, 5'b0);
        tick();

        // Token: SYNC, PID, CRC5
        for (int f = 0; f < 3; f++) begin
            rcv = 5'(1 << f);
            n = 0; stray = 0;
            for (int i = 0; i < lens[f]; i++) begin
                strobe(e);
                if (e == 5'(1 << f)) n++;
                else stray++;
            end
            chk($sformatf("tok%0d_cnt", f), n, lens[f]);
            chk($sformatf("tok%0d_stray", f), stray, 0);
            chk($sformatf("tok%0d_rx", f), rx, 5'(1 << f));
            tick();
            rcv = '0;
            tick();
            chk($sformatf("tok%0d_rx_off", f), rx, 5'b0);
        end

        // DATA: 64 bits then an overrunning 65th strobe
        rcv = 5'b01000;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            strobe(e);
            if (e == 5'b01000) n++;
        end
        chk("data_cnt", n, 64);
        chk("data_rx", rx, 5'b01000);
        chk("data_ovr_pre", field_overrun, 1'b0);
        strobe(e);
        chk("data_en65", e, 5'b0);
        chk("data_ovr", field_overrun, 1'b1);
        chk("data_rx65", rx, 5'b01000);
        rcv = '0;
        tick(); tick();
        chk("ovr_sticky", field_overrun, 1'b1);
        eop = 1'b1;
        tick();
        eop = 1'b0;
        chk("ovr_eop_clr", field_overrun, 1'b0);

        // Conflicting selects
        rcv = 5'b00110;
        shift_strobe = 1'b1;
        #1;
        chk("conf_flag", field_conflict, 1'b1);
        chk("conf_en", en, 5'b0);
        chk("conf_rx", rx, 5'b0);
        tick();
        shift_strobe = 1'b0;
        chk("conf_rx_after", rx, 5'b0);
        chk("conf_ovr", field_overrun, 1'b0);
        rcv = '0;
        #1;
        chk("conf_clear", field_conflict, 1'b0);
        tick();

        // Direct SYNC->PID with a strobe in the transition cycle
        rcv = 5'b00001;
        for (int i = 0; i < 3; i++) strobe(e);
        rcv = 5'b00010;
        strobe(e);
        chk("xfer_en", e, 5'b00010);
        for (int i = 0; i < 6; i++) strobe(e);
        chk("xfer_rx7", rx, 5'b0);
        strobe(e);
        chk("xfer_en8", e, 5'b00010);
        chk("xfer_rx8", rx, 5'b00010);
        rcv = '0;
        tick();

        // EOP beats a simultaneous strobe
        rcv = 5'b00001;
        eop = 1'b1;
        shift_strobe = 1'b1;
        #1;
        chk("eop_pri_en", en, 5'b0);
        tick();
        shift_strobe = 1'b0;
        eop = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            strobe(e);
            if (e == 5'b00001) n++;
        end
        chk("eop_pri_cnt", n, 8);
        chk("eop_pri_rx", rx, 5'b00001);
        rcv = '0;
        tick();

        // Stall: CRC16, 3 strobes, then a long gap
        rcv = 5'b10000;
        for (int i = 0; i < 3; i++) strobe(e);
        pulses = 0;
        repeat (70) begin
            tick();
            if (stall_timeout) pulses++;
        end
`ifdef RX_SEQ_WATCHDOG_EN
        chk("wdog_pulses", pulses, 1);
`else
        chk("wdog_pulses", pulses, 0);
`endif
        n = 0;
        for (int i = 0; i < 13; i++) begin
            strobe(e);
            if (e == 5'b10000) n++;
            if (i == 11) chk("crc16_rx12", rx, 5'b0);
        end
        chk("crc16_cnt", n, 13);
        chk("crc16_rx", rx, 5'b10000);
        rcv = '0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
